result_reader: RTL and testbench
================================

# result_reader

Reads the finished result matrix out of the result SRAM once the matrix-multiply controller signals completion, and streams it to the output pins as bytes over a valid/ready handshake. It is the read-side counterpart of the controller's RAM write path: the controller writes results via `ram_en`/`web`, and this block reads them back and serialises them. It sits between the result SRAM read port and the chip-level output interface.

## Interface
- `NUM_WORDS`, default 16: result words to read, at addresses 0..NUM_WORDS-1; must be at least 1.
- `ADDR_W`, default 4: SRAM address width; must satisfy 2^ADDR_W ≥ NUM_WORDS.
- `DATA_W`, default 32: SRAM word width; must be a multiple of 8.
- `clk` input 1: the single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a dump; connected to controller `finish`.
- `ram_rdata` input DATA_W: SRAM read data, valid one cycle after the read is issued.
- `out_ready` input 1: downstream accepts the byte this cycle.
- `ram_en` output 1: SRAM enable, active-high.
- `web` output 1: SRAM write enable, active-low; this block drives it constant 1 (read only).
- `ram_addr` output ADDR_W: SRAM read address.
- `out_data` output 8: current output byte.
- `out_valid` output 1: `out_data` is valid.
- `out_last` output 1: marks the final byte of the dump.
- `busy` output 1: a dump is in progress.
- `done` output 1: one-cycle pulse after the final byte is transferred.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- **IDLE**
  - `start`=1 → READ.
  - The word address counter clears to 0.
- **READ**
  - `ram_en`=1 and `ram_addr`=word address; → WAIT unconditionally.
- **WAIT**
  - `ram_rdata` is captured into the DATA_W shift buffer at the end of the cycle.
  - The byte counter clears to 0; → SEND.
- **SEND**
  - `out_valid`=1 and `out_data`=buffer[7:0], i.e. bytes go out LSB-first.
  - On a transfer (`out_valid` && `out_ready`):
    - the buffer shifts right by 8;
    - the byte counter increments.
  - After the transfer of byte DATA_W/8-1:
    - if word address = NUM_WORDS-1 → DONE;
    - else word address +1 → READ.
- **DONE**
  - `done`=1 for exactly one cycle; → IDLE.
- `out_last`=1 only in SEND, and only while byte counter = DATA_W/8-1 and word address = NUM_WORDS-1.
- `busy`=1 in every state except IDLE.
- `start` is ignored in all states other than IDLE; no queuing.
- Stalling:
  - `out_ready`=0 holds `out_data`, `out_valid`, `out_last` and all counters stable.
  - `out_valid` never drops once raised until the transfer completes.
- `ram_en`=0 in all states except READ, so exactly one SRAM read is issued per word.
- Counters are sized for their maximum value and never wrap within a dump:
  - word address: ADDR_W bits;
  - byte counter: clog2(DATA_W/8) bits, minimum 1.

## Timing
- Reset values: state IDLE. Outputs:
  - `ram_en`=0, `web`=1, `ram_addr`=0;
  - `out_data`=0, `out_valid`=0, `out_last`=0;
  - `busy`=0, `done`=0.
- Reset takes effect at the next rising edge from any state, including mid-dump:
  - the partially sent word is discarded;
  - no `done` pulse is issued;
  - the next `start` restarts the dump from address 0.
- Startup latency: `start` sampled high at edge 0 gives:
  - READ in cycle 1;
  - WAIT in cycle 2;
  - first `out_valid` in cycle 3.
- Throughput with `out_ready`=1: 2 + DATA_W/8 cycles per word, i.e. 6 cycles for DATA_W=32.
- Full dump with `out_ready`=1 and default parameters:
  - last byte in cycle 96;
  - `done` in cycle 97;
  - IDLE, `busy`=0 in cycle 98.
- `start` held high through DONE:
  - it is seen in IDLE at cycle 98;
  - a new dump begins with READ in cycle 99.

## Test plan
- **Full dump, no backpressure.** SRAM preloaded with word[i] = 32'hA0B0C000 + i; `start` pulse; `out_ready`=1.
  - 64 bytes in order, starting 00,C0,B0,A0 then 01,C0,B0,A0, and so on.
  - `out_last` set only on byte 64, in cycle 96; `done` in cycle 97; `ram_en` pulsed 16 times.
- **Backpressure.** `out_ready` toggles 1,0,0,1 repeating.
  - Identical byte sequence; no byte duplicated or dropped.
  - `out_data` stable while stalled.
- **`start` re-asserted mid-dump** at cycle 20.
  - Ignored: byte stream and `done` timing identical to the first scenario.
- **Reset mid-dump.** `rst` asserted at cycle 40 during SEND of word 6.
  - Next cycle: all outputs at their reset values.
  - A subsequent `start` streams from word 0 byte 0.
- **Single-word dump.** Parameters NUM_WORDS=1, DATA_W=8; word 8'h5A.
  - One byte 5A in cycle 3 with `out_last`=1.
  - `done` in cycle 4.
- **Back-to-back dumps.** `start` held high continuously.
  - Second dump's READ occurs exactly one cycle after the first dump's IDLE cycle.
  - Second dump's data sequence is identical to the first.

Source files
------------

// File: rtl/result_reader.sv
// result_reader: once the controller finishes, reads result words 0..NUM_WORDS-1
// from the result SRAM and streams them out LSB-first as bytes over valid/ready.
module result_reader #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              out_ready,
  output logic              ram_en,
  output logic              web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] buffer;
  logic              last_word;

  assign last_word = (word_addr == LAST_WORD);
  assign web       = 1'b1;
  assign ram_addr  = word_addr;
  // The low byte of the shift buffer is the output byte; the final shift empties it.
  assign out_data  = buffer[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_addr <= '0;
      byte_cnt  <= '0;
      buffer    <= '0;
      ram_en    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          word_addr <= '0;
          if (start) begin
            state  <= READ;
            ram_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        READ: begin
          ram_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          buffer    <= ram_rdata;
          byte_cnt  <= '0;
          out_valid <= 1'b1;
          out_last  <= last_word && (LAST_BYTE == '0);
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            buffer <= buffer >> 8;
            if (byte_cnt == LAST_BYTE) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (last_word) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                word_addr <= word_addr + 1'b1;
                ram_en    <= 1'b1;
                state     <= READ;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              out_last <= last_word && ((byte_cnt + 1'b1) == LAST_BYTE);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ram_en    <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: SRAM model, byte-stream reference
// model built from memory contents, and per-scenario cycle-accurate checks.
module tb_result_reader;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int WORD_CYC = 2 + NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, out_ready;
  logic [DW-1:0] ram_rdata;
  logic          ram_en, web, out_valid, out_last, busy, done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    out_data;
  logic [DW-1:0] mem [NW];

  logic       start2, out_ready2;
  logic [7:0] ram_rdata2, mem2;
  logic       ram_en2, web2, out_valid2, out_last2, busy2, done2;
  logic [0:0] ram_addr2;
  logic [7:0] out_data2;

  result_reader #(.NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_rdata(ram_rdata), .out_ready(out_ready),
    .ram_en(ram_en), .web(web), .ram_addr(ram_addr), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done));

  result_reader #(.NUM_WORDS(1), .ADDR_W(1), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ram_rdata(ram_rdata2), .out_ready(out_ready2),
    .ram_en(ram_en2), .web(web2), .ram_addr(ram_addr2), .out_data(out_data2),
    .out_valid(out_valid2), .out_last(out_last2), .busy(busy2), .done(done2));

  always @(posedge clk) begin
    if (ram_en && web) ram_rdata <= mem[ram_addr];
    if (ram_en2 && web2) ram_rdata2 <= (ram_addr2 == 1'b0) ? mem2 : 8'h00;
  end

  int passed = 0;
  int total  = 0;

  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          en_cycles[$];
  int          done_cycles[$];
  int          last_cnt, last_idx, last_cyc, done_cnt, idle_cyc, stall_err, proto_err;
  logic [17:0] rst_snap;
  localparam logic [17:0] RESET_SNAP = {1'b0, 1'b1, 4'd0, 8'd0, 4'b0000};

  // Reference byte stream: every word, low byte first.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < NB; b++)
        exp_q.push_back(8'((mem[i] >> (8 * b)) & 32'hFF));
  endtask

  function automatic int count_diff(input int offset);
    int n = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (offset + k >= got.size() || got[offset + k] !== exp_q[k]) n++;
    return n;
  endfunction

  // mode: 0 ready=1, 1 ready 1,0,0,1, 2 random ready, 3 start held high
  task automatic collect(input int mode, input int restart_at, input int rst_at,
                         input int want_done, input int max_cyc);
    logic       pstall = 1'b0, plast = 1'b0;
    logic [7:0] pdata = 8'h00;
    got.delete(); en_cycles.delete(); done_cycles.delete();
    last_cnt = 0; last_idx = -1; last_cyc = -1; done_cnt = 0; idle_cyc = -1;
    stall_err = 0; proto_err = 0; rst_snap = '1;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (mode != 3) start = (cyc == restart_at);
      rst = (cyc == rst_at);
      case (mode)
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (pstall && (!out_valid || out_data !== pdata || out_last !== plast)) stall_err++;
      if (out_last && !out_valid) proto_err++;
      if (ram_en) en_cycles.push_back(cyc);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          last_cnt++; last_idx = got.size(); last_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++; done_cycles.push_back(cyc);
      end
      if (!busy && idle_cyc < 0 && done_cnt > 0) idle_cyc = cyc;
      if (cyc == rst_at + 1)
        rst_snap = {ram_en, web, ram_addr, out_data, out_valid, out_last, busy, done};
      pstall = out_valid && !out_ready; pdata = out_data; plast = out_last;
      if (want_done > 0 && done_cnt >= want_done && idle_cyc >= 0 && cyc > idle_cyc + 1) break;
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1; rst = 1'b0;
    if (busy) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NW; i++) mem[i] = 32'hA0B0C000 + 32'(i);
  endtask

  task automatic test_reset();
    logic [17:0] snap;
    snap = {ram_en, web, ram_addr, out_data, out_valid, out_last, busy, done};
    total++;
    if (snap !== RESET_SNAP) $display("FAIL reset_outputs: got %h expected %h", snap, RESET_SNAP);
    else passed++;
    total++;
    if ({ram_en2, web2, out_valid2, out_last2, busy2, done2} !== 6'b010000)
      $display("FAIL reset_outputs_single: got %b expected 010000",
               {ram_en2, web2, out_valid2, out_last2, busy2, done2});
    else passed++;
  endtask

  task automatic test_full_dump();
    int bad = 0;
    fill_pattern(); build_exp();
    collect(0, -1, -1, 1, 300);
    total++;
    if (got.size() !== NW * NB) $display("FAIL full_count: got %0d expected %0d", got.size(), NW * NB);
    else passed++;
    total++;
    if (count_diff(0) !== 0) $display("FAIL full_data: got %0d bad bytes expected 0", count_diff(0));
    else passed++;
    total++;
    if (got.size() >= 4 && {got[0], got[1], got[2], got[3]} !== 32'h00C0B0A0)
      $display("FAIL full_first_word: got %h expected 00c0b0a0", {got[0], got[1], got[2], got[3]});
    else passed++;
    total++;
    if (last_cnt !== 1 || last_idx !== NW * NB)
      $display("FAIL full_last_pos: got cnt %0d idx %0d expected 1 %0d", last_cnt, last_idx, NW * NB);
    else passed++;
    total++;
    if (last_cyc !== NW * WORD_CYC) $display("FAIL full_last_cycle: got %0d expected %0d", last_cyc, NW * WORD_CYC);
    else passed++;
    total++;
    if (done_cnt !== 1 || done_cycles.size() < 1 || done_cycles[0] !== NW * WORD_CYC + 1)
      $display("FAIL full_done_cycle: got cnt %0d expected cycle %0d", done_cnt, NW * WORD_CYC + 1);
    else passed++;
    total++;
    if (idle_cyc !== NW * WORD_CYC + 2) $display("FAIL full_idle_cycle: got %0d expected %0d", idle_cyc, NW * WORD_CYC + 2);
    else passed++;
    for (int k = 0; k < en_cycles.size(); k++) if (en_cycles[k] !== 1 + k * WORD_CYC) bad++;
    total++;
    if (en_cycles.size() !== NW || bad !== 0)
      $display("FAIL full_ram_en: got %0d pulses %0d misplaced expected %0d 0", en_cycles.size(), bad, NW);
    else passed++;
    total++;
    if (proto_err !== 0) $display("FAIL full_last_without_valid: got %0d expected 0", proto_err);
    else passed++;
  endtask

  task automatic test_backpressure(input int mode);
    collect(mode, -1, -1, 1, 1000);
    total++;
    if (got.size() !== NW * NB || count_diff(0) !== 0)
      $display("FAIL bp%0d_data: got %0d bytes %0d bad expected %0d 0", mode, got.size(), count_diff(0), NW * NB);
    else passed++;
    total++;
    if (stall_err !== 0) $display("FAIL bp%0d_stall_stable: got %0d changes expected 0", mode, stall_err);
    else passed++;
    total++;
    if (last_cnt !== 1 || last_idx !== NW * NB)
      $display("FAIL bp%0d_last: got cnt %0d idx %0d expected 1 %0d", mode, last_cnt, last_idx, NW * NB);
    else passed++;
    total++;
    if (done_cnt !== 1 || en_cycles.size() !== NW)
      $display("FAIL bp%0d_done_reads: got %0d %0d expected 1 %0d", mode, done_cnt, en_cycles.size(), NW);
    else passed++;
  endtask

  task automatic test_random_data();
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    build_exp();
    test_backpressure(2);
    fill_pattern(); build_exp();
  endtask

  task automatic test_restart_ignored();
    collect(0, 20, -1, 1, 300);
    total++;
    if (got.size() !== NW * NB || count_diff(0) !== 0)
      $display("FAIL restart_data: got %0d bytes %0d bad expected %0d 0", got.size(), count_diff(0), NW * NB);
    else passed++;
    total++;
    if (done_cnt !== 1 || done_cycles.size() < 1 || done_cycles[0] !== NW * WORD_CYC + 1)
      $display("FAIL restart_done: got cnt %0d expected cycle %0d", done_cnt, NW * WORD_CYC + 1);
    else passed++;
    total++;
    if (en_cycles.size() !== NW) $display("FAIL restart_reads: got %0d expected %0d", en_cycles.size(), NW);
    else passed++;
  endtask

  task automatic test_mid_reset();
    collect(0, -1, 40, 0, 45);
    total++;
    if (rst_snap !== RESET_SNAP) $display("FAIL midrst_outputs: got %h expected %h", rst_snap, RESET_SNAP);
    else passed++;
    total++;
    if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d expected 0", done_cnt);
    else passed++;
    total++;
    if (got.size() !== 6 * NB + 2) $display("FAIL midrst_partial: got %0d expected %0d", got.size(), 6 * NB + 2);
    else passed++;
    collect(0, -1, -1, 1, 300);
    total++;
    if (got.size() !== NW * NB || count_diff(0) !== 0)
      $display("FAIL midrst_restream: got %0d bytes %0d bad expected %0d 0", got.size(), count_diff(0), NW * NB);
    else passed++;
    total++;
    if (done_cycles.size() < 1 || done_cycles[0] !== NW * WORD_CYC + 1)
      $display("FAIL midrst_done: got %0d pulses expected cycle %0d", done_cycles.size(), NW * WORD_CYC + 1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    collect(3, -1, -1, 2, 400);
    total++;
    if (idle_cyc !== NW * WORD_CYC + 2) $display("FAIL b2b_idle: got %0d expected %0d", idle_cyc, NW * WORD_CYC + 2);
    else passed++;
    total++;
    if (en_cycles.size() <= NW || en_cycles[NW] !== NW * WORD_CYC + 3)
      $display("FAIL b2b_second_read: got %0d pulses expected read at %0d", en_cycles.size(), NW * WORD_CYC + 3);
    else passed++;
    total++;
    if (got.size() < 2 * NW * NB || count_diff(0) !== 0 || count_diff(NW * NB) !== 0)
      $display("FAIL b2b_data: got %0d bytes %0d/%0d bad expected %0d 0/0",
               got.size(), count_diff(0), count_diff(NW * NB), 2 * NW * NB);
    else passed++;
    total++;
    if (done_cycles.size() < 2 || done_cycles[1] !== 2 * (NW * WORD_CYC + 1) + 1)
      $display("FAIL b2b_second_done: got %0d pulses expected cycle %0d", done_cycles.size(), 2 * (NW * WORD_CYC + 1) + 1);
    else passed++;
  endtask

  task automatic test_single_word();
    logic [9:0] c3;
    int valid_cnt = 0, done_at = -1;
    c3 = '0;
    mem2 = 8'h5A; out_ready2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (out_valid2) valid_cnt++;
      if (cyc == 3) c3 = {out_valid2, out_last2, out_data2};
      if (done2 && done_at < 0) done_at = cyc;
      @(posedge clk); #1;
    end
    total++;
    if (c3 !== {1'b1, 1'b1, 8'h5A}) $display("FAIL single_byte: got %h expected %h", c3, {1'b1, 1'b1, 8'h5A});
    else passed++;
    total++;
    if (valid_cnt !== 1) $display("FAIL single_valid_count: got %0d expected 1", valid_cnt);
    else passed++;
    total++;
    if (done_at !== 4) $display("FAIL single_done: got %0d expected 4", done_at);
    else passed++;
    total++;
    if (busy2 !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy2);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start2 = 1'b0; out_ready2 = 1'b1; mem2 = 8'h00;
    fill_pattern();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_full_dump();
    test_backpressure(1);
    test_random_data();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    test_single_word();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
